// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core port, host port and RAM port.
// The arbiter takes the slave view; the surrounding top level takes master.
interface dmem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 17
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data RAM between the core and the host port.
// Core has priority; a starvation counter forces a host grant after MAX_WAIT.
module dmem_arbiter #(
    parameter int AW       = 17,
    parameter int DW       = 17,
    parameter int MAX_WAIT = 4
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        C_RD,
        H_RD
    } state_e;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic          host_starved;
    logic          core_win;
    logic          host_win;
    logic          core_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    always_comb begin
        state_d      = state_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        core_rdata   = '0;
        core_done    = 1'b0;

        host_starved = bus.host_req && (wait_q == WAIT_MAX);
        core_win     = (state_q == IDLE) && bus.core_req && !host_starved;
        host_win     = (state_q == IDLE) && bus.host_req && !core_win;

        unique case (state_q)
            IDLE: begin
                if (core_win) begin
                    mem_we    = bus.core_we;
                    mem_addr  = bus.core_addr;
                    mem_wdata = bus.core_wdata;
                    core_done = bus.core_we;
                    if (!bus.core_we) state_d = C_RD;
                end else if (host_win) begin
                    mem_we    = bus.host_we;
                    mem_addr  = bus.host_addr;
                    mem_wdata = bus.host_wdata;
                    if (bus.host_we) host_ack_d = 1'b1;
                    else             state_d    = H_RD;
                end
            end
            C_RD: begin
                core_rdata = bus.mem_rdata;
                core_done  = 1'b1;
                state_d    = IDLE;
            end
            H_RD: begin
                host_rdata_d = bus.mem_rdata;
                host_ack_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        core_stall = bus.core_req && !core_done;

        // Waiting counts every cycle the host is refused, read phases included.
        if (!bus.host_req || host_win) wait_d = '0;
        else if (wait_q != WAIT_MAX)   wait_d = wait_q + 1'b1;
        else                           wait_d = wait_q;

        if (reset) begin
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            core_rdata = '0;
            core_stall = bus.core_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.core_rdata = core_rdata;
    assign bus.core_stall = core_stall;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vectors against a behavioural RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
    typedef logic [16:0] w_t;

    typedef struct {
        logic rst;
        logic cr;
        logic cw;
        w_t   ca;
        w_t   cd;
        logic hr;
        logic hw;
        w_t   ha;
        w_t   hd;
        logic e_we;
        w_t   e_addr;
        w_t   e_wd;
        logic e_stall;
        w_t   e_crd;
        logic e_ack;
        w_t   e_hrd;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    w_t   mem [0:(1<<17)-1];

    dmem_arbiter_if #(.AW(17), .DW(17)) bus ();

    dmem_arbiter #(.AW(17), .DW(17), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic vec_t mk(
        input logic rst, cr, cw, input w_t ca, cd,
        input logic hr, hw, input w_t ha, hd,
        input logic e_we, input w_t e_addr, e_wd,
        input logic e_stall, input w_t e_crd,
        input logic e_ack, input w_t e_hrd
    );
        vec_t v;
        v.rst = rst;   v.cr = cr;         v.cw = cw;
        v.ca = ca;     v.cd = cd;
        v.hr = hr;     v.hw = hw;
        v.ha = ha;     v.hd = hd;
        v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_stall = e_stall; v.e_crd = e_crd;
        v.e_ack = e_ack;     v.e_hrd = e_hrd;
        return v;
    endfunction

    task automatic chk(input string nm, input w_t act, input w_t exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset          = v.rst;
        bus.core_req   = v.cr;
        bus.core_we    = v.cw;
        bus.core_addr  = v.ca;
        bus.core_wdata = v.cd;
        bus.host_req   = v.hr;
        bus.host_we    = v.hw;
        bus.host_addr  = v.ha;
        bus.host_wdata = v.hd;
        @(negedge clk);
        chk({tag, ".mem_we"},     {16'b0, bus.mem_we},     {16'b0, v.e_we});
        chk({tag, ".mem_addr"},   bus.mem_addr,            v.e_addr);
        chk({tag, ".mem_wdata"},  bus.mem_wdata,           v.e_wd);
        chk({tag, ".core_stall"}, {16'b0, bus.core_stall}, {16'b0, v.e_stall});
        chk({tag, ".core_rdata"}, bus.core_rdata,          v.e_crd);
        chk({tag, ".host_ack"},   {16'b0, bus.host_ack},   {16'b0, v.e_ack});
        chk({tag, ".host_rdata"}, bus.host_rdata,          v.e_hrd);
    endtask

    initial begin
        vec_t tbl[$];
        w_t   e3_addr [8];
        logic e3_st   [8];
        w_t   e3_crd  [8];
        logic e3_ack  [8];

        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.core_req = 1'b0;   bus.core_we = 1'b0;
        bus.core_addr = '0;    bus.core_wdata = '0;
        bus.host_req = 1'b0;   bus.host_we = 1'b0;
        bus.host_addr = '0;    bus.host_wdata = '0;

        // rst cr cw ca cd | hr hw ha hd | we addr wd stall crd ack hrd
        tbl.push_back(mk(1,1,0,'h5,0,     1,0,'h6,0,     0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,0));
        // core write then read back
        tbl.push_back(mk(0,1,1,'h10,'h1ABCD, 0,0,0,0, 1,'h10,'h1ABCD,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,'h10,0,    0,0,0,0,       0,'h10,0,1,0,0,0));
        tbl.push_back(mk(0,1,0,'h10,0,    0,0,0,0,       0,0,0,0,'h1ABCD,0,0));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,0));
        // host write then host read
        tbl.push_back(mk(0,0,0,0,0,       1,1,'h20,'h555, 1,'h20,'h555,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,       1,0,'h20,0,    0,'h20,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,       1,0,'h20,0,    0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,1,'h555));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,'h555));
        // simultaneous writes: core first, host next cycle
        tbl.push_back(mk(0,1,1,'h30,'h11111, 1,1,'h40,'h2222,
                         1,'h30,'h11111,0,0,0,'h555));
        tbl.push_back(mk(0,0,0,0,0, 1,1,'h40,'h2222, 1,'h40,'h2222,0,0,0,'h555));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,1,'h555));
        // back-to-back host writes
        tbl.push_back(mk(0,0,0,0,0,       1,1,'h50,'h3,  1,'h50,'h3,0,0,0,'h555));
        tbl.push_back(mk(0,0,0,0,0,       1,1,'h51,'h4,  1,'h51,'h4,0,0,1,'h555));
        tbl.push_back(mk(0,0,0,0,0,       1,1,'h52,'h5,  1,'h52,'h5,0,0,1,'h555));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,1,'h555));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,'h555));
        // back-to-back core reads verify the RAM contents
        tbl.push_back(mk(0,1,0,'h51,0,    0,0,0,0,       0,'h51,0,1,0,0,'h555));
        tbl.push_back(mk(0,1,0,'h51,0,    0,0,0,0,       0,0,0,0,'h4,0,'h555));
        tbl.push_back(mk(0,1,0,'h30,0,    0,0,0,0,       0,'h30,0,1,0,0,'h555));
        tbl.push_back(mk(0,1,0,'h30,0,    0,0,0,0,       0,0,0,0,'h11111,0,'h555));
        tbl.push_back(mk(0,1,0,'h40,0,    0,0,0,0,       0,'h40,0,1,0,0,'h555));
        tbl.push_back(mk(0,1,0,'h40,0,    0,0,0,0,       0,0,0,0,'h2222,0,'h555));
        tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,       0,0,0,0,0,0,'h555));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Starvation: core streams reads, host read forced on 5th waiting cycle.
        e3_addr = '{'h10, 0, 'h10, 0, 'h50, 0, 'h10, 0};
        e3_st   = '{1, 0, 1, 0, 1, 1, 1, 0};
        e3_crd  = '{0, 'h1ABCD, 0, 'h1ABCD, 0, 0, 0, 'h1ABCD};
        e3_ack  = '{0, 0, 0, 0, 0, 0, 1, 0};
        for (int c = 0; c < 8; c++) begin
            apply(mk(0,1,0,'h10,0, c < 6,0,'h50,0,
                     0,e3_addr[c],0,e3_st[c],e3_crd[c],e3_ack[c],
                     (c < 6) ? w_t'('h555) : w_t'('h3)),
                  $sformatf("starve%0d", c));
        end
        apply(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,'h3), "starve_end");

        // Reset during a core read phase, then during a host read phase.
        apply(mk(0,1,0,'h40,0, 0,0,0,0,    0,'h40,0,1,0,0,'h3), "rst_c0");
        apply(mk(1,1,0,'h40,0, 0,0,0,0,    0,0,0,1,0,0,'h3),    "rst_c1");
        apply(mk(0,0,0,0,0,    1,0,'h51,0, 0,'h51,0,0,0,0,0),   "rst_h0");
        apply(mk(1,0,0,0,0,    1,0,'h51,0, 0,0,0,0,0,0,0),      "rst_h1");
        apply(mk(0,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0,0),      "rst_h2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
